// File: rtl/ins_loader.sv
// Byte-stream program loader feeding a 256 x 21-bit instruction RAM.
// A length byte, then three bytes per word; the CPU stays in reset until the whole program is resident.
module ins_loader (
  input  logic        CLK,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  input  logic [7:0]  Addr,
  output logic [20:0] INS,
  output logic        cpu_reset,
  output logic [8:0]  words_loaded,
  output logic        load_done
);

  localparam logic [2:0] ST_LEN  = 3'd0;
  localparam logic [2:0] ST_B0   = 3'd1;
  localparam logic [2:0] ST_B1   = 3'd2;
  localparam logic [2:0] ST_B2   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_RUN  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [8:0]  target_q, target_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [8:0]  wl_q, wl_d;
  logic [8:0]  wl_inc_s;
  logic        xfer_s;
  logic        ram_we_s;
  logic [20:0] ram_wdata_s;
  logic [20:0] ram_q [0:255];

  assign xfer_s      = in_valid & in_ready;
  assign wl_inc_s    = wl_q + 9'd1;
  assign ram_wdata_s = {in_data[4:0], b1_q, b0_q};

  // Next-state and datapath update for the loader FSM
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    wl_d     = wl_q;
    ram_we_s = 1'b0;
    case (state_q)
      ST_LEN: begin
        if (xfer_s) begin
          target_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          state_d  = ST_B0;
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_B0: begin
        if (xfer_s) begin
          b0_d    = in_data;
          state_d = ST_B1;
        end else begin
          state_d = ST_B0;
        end
      end
      ST_B1: begin
        if (xfer_s) begin
          b1_d    = in_data;
          state_d = ST_B2;
        end else begin
          state_d = ST_B1;
        end
      end
      ST_B2: begin
        if (xfer_s) begin
          ram_we_s = 1'b1;
          wl_d     = wl_inc_s;
          state_d  = (wl_inc_s == target_q) ? ST_DONE : ST_B0;
        end else begin
          state_d = ST_B2;
        end
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (reload) begin
          state_d = ST_LEN;
          wl_d    = 9'd0;
          b0_d    = 8'd0;
          b1_d    = 8'd0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_LEN;
        wl_d    = 9'd0;
      end
    endcase
  end

  // Loader state registers with asynchronous reset
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LEN;
      target_q <= 9'd0;
      b0_q     <= 8'd0;
      b1_q     <= 8'd0;
      wl_q     <= 9'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      wl_q     <= wl_d;
    end
  end

  // Instruction RAM has no reset so a program survives reset; index wraps at 8 bits
  always_ff @(posedge CLK) begin
    if (ram_we_s) begin
      ram_q[wl_q[7:0]] <= ram_wdata_s;
    end
  end

  // Status outputs and zero-latency instruction fetch, gated to loaded words in RUN
  always_comb begin
    in_ready     = (state_q == ST_LEN) || (state_q == ST_B0) ||
                   (state_q == ST_B1)  || (state_q == ST_B2);
    cpu_reset    = (state_q != ST_RUN);
    load_done    = (state_q == ST_DONE);
    words_loaded = wl_q;
    if ((state_q == ST_RUN) && ({1'b0, Addr} < wl_q)) begin
      INS = ram_q[Addr];
    end else begin
      INS = 21'd0;
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// Directed self-checking bench for ins_loader; inputs change on the falling edge, outputs sampled there.
module tb_ins_loader;

  logic        CLK = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic [7:0]  Addr;
  logic [20:0] INS;
  logic        cpu_reset;
  logic [8:0]  words_loaded;
  logic        load_done;

  int checks = 0;
  int errors = 0;
  int done_cnt;
  logic hold_ok;

  ins_loader dut (
    .CLK          (CLK),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .Addr         (Addr),
    .INS          (INS),
    .cpu_reset    (cpu_reset),
    .words_loaded (words_loaded),
    .load_done    (load_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one byte, transferred on the next rising edge; returns at the following falling edge
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // one byte followed by one idle cycle
  task automatic send_gap(input logic [7:0] b);
    send(b);
    in_data = 8'hAA;
    @(negedge CLK);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge CLK);
    reload = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    reload   = 1'b0;
    Addr     = 8'd0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_words", words_loaded, 0);
    chk("rst_ins", INS, 0);
    chk("rst_load_done", load_done, 0);
    @(negedge CLK);
    reset = 1'b0;

    // basic load of two words
    send(8'h02);
    send(8'h05); send(8'h00); send(8'h0C);
    chk("basic_mid_words", words_loaded, 1);
    chk("basic_mid_ins", INS, 0);
    chk("basic_mid_cpu_reset", cpu_reset, 1);
    send(8'h07); send(8'h08); send(8'h0C);
    chk("basic_done_pulse", load_done, 1);
    chk("basic_done_cpu_reset", cpu_reset, 1);
    chk("basic_done_in_ready", in_ready, 0);
    chk("basic_words", words_loaded, 2);
    @(negedge CLK);
    chk("basic_run_load_done", load_done, 0);
    chk("basic_run_cpu_reset", cpu_reset, 0);
    chk("basic_run_in_ready", in_ready, 0);
    Addr = 8'd0; #1;
    chk("basic_ins0", INS, 21'h0C0005);
    Addr = 8'd1; #1;
    chk("basic_ins1", INS, 21'h0C0807);
    Addr = 8'd2; #1;
    chk("basic_ins2", INS, 0);

    // valid while not ready is not consumed
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge CLK);
    in_valid = 1'b0;
    chk("run_ignore_words", words_loaded, 2);
    chk("run_ignore_cpu_reset", cpu_reset, 0);

    // reload, then same stream with gaps
    pulse_reload();
    chk("reload_cpu_reset", cpu_reset, 1);
    chk("reload_words", words_loaded, 0);
    chk("reload_in_ready", in_ready, 1);
    send_gap(8'h02);
    send_gap(8'h05); send_gap(8'h00); send_gap(8'h0C);
    repeat (3) @(negedge CLK);
    chk("gap_hold_words", words_loaded, 1);
    send_gap(8'h07); send_gap(8'h08);
    in_valid = 1'b1;
    in_data  = 8'h0C;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("gap_done_pulse", load_done, 1);
    @(negedge CLK);
    chk("gap_words", words_loaded, 2);
    chk("gap_in_ready_run", in_ready, 0);
    Addr = 8'd0; #1;
    chk("gap_ins0", INS, 21'h0C0005);
    Addr = 8'd1; #1;
    chk("gap_ins1", INS, 21'h0C0807);

    // full 256-word load
    pulse_reload();
    done_cnt = 0;
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(i[7:0]);
      send(~i[7:0]);
      send(i[7:0]);
      if (load_done) done_cnt++;
    end
    @(negedge CLK);
    if (load_done) done_cnt++;
    chk("full_done_once", done_cnt, 1);
    chk("full_words", words_loaded, 256);
    chk("full_cpu_reset", cpu_reset, 0);
    Addr = 8'd255; #1;
    chk("full_ins255", INS, 21'h1F00FF);
    Addr = 8'd0; #1;
    chk("full_ins0", INS, 21'h00FF00);

    // reload with all-ones word; cpu_reset held through load and DONE
    pulse_reload();
    hold_ok = cpu_reset;
    send(8'h01); hold_ok = hold_ok & cpu_reset;
    send(8'hFF); hold_ok = hold_ok & cpu_reset;
    send(8'hFF); hold_ok = hold_ok & cpu_reset;
    send(8'hFF);
    chk("ff_done_pulse", load_done, 1);
    chk("ff_cpu_reset_hold", hold_ok & cpu_reset, 1);
    @(negedge CLK);
    chk("ff_run_cpu_reset", cpu_reset, 0);
    Addr = 8'd0; #1;
    chk("ff_ins0", INS, 21'h1FFFFF);
    Addr = 8'd1; #1;
    chk("ff_ins1", INS, 0);

    // reload during B1 has no effect
    pulse_reload();
    send(8'h01);
    send(8'h05);
    reload = 1'b1;
    send(8'h00);
    send(8'h0C);
    chk("b1reload_done_pulse", load_done, 1);
    reload = 1'b0;
    @(negedge CLK);
    chk("b1reload_words", words_loaded, 1);
    chk("b1reload_cpu_reset", cpu_reset, 0);
    Addr = 8'd0; #1;
    chk("b1reload_ins0", INS, 21'h0C0005);

    // asynchronous reset mid-load
    pulse_reload();
    send(8'h03);
    send(8'h01); send(8'h02); send(8'h03);
    chk("midrst_pre_words", words_loaded, 1);
    send(8'h04);
    reset = 1'b1;
    #1;
    chk("midrst_words", words_loaded, 0);
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_ins", INS, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge CLK);
    reset = 1'b0;
    send(8'h01);
    send(8'h11); send(8'h22); send(8'h03);
    chk("postrst_done_pulse", load_done, 1);
    @(negedge CLK);
    chk("postrst_words", words_loaded, 1);
    Addr = 8'd0; #1;
    chk("postrst_ins0", INS, 21'h032211);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
